mem_sweep_ctrl: RTL
===================

// Module: mem_sweep_ctrl
// PURPOSE
//  Sequencer for a wide vector memory (one row = no_of_units*element_width bits; async read, sync write).
//  On start, it sweeps `length` consecutive rows from base_read_address into a fixed-latency datapath.
//  It optionally writes each result row back from base_write_address, then pulses finish.
//  Sits between the top-level iteration FSM and a vector memory / datapath pair (R, X, P vectors).
// PARAMETERS
//  element_width  32  bits per element (documentation only; no data passes through this block)
//  no_of_units    8   elements per memory row (documentation only)
//  address_width  20  width of all row addresses and of length
//  DP_LATENCY     4   datapath pipeline depth in cycles, >=1; input row at cycle t -> result valid at t+DP_LATENCY
// PORTS
//  clk                 in   1              rising-edge clock
//  rst_n               in   1              asynchronous, active-low reset
//  start               in   1              1-cycle request; sampled only in IDLE
//  base_read_address   in   address_width  first row to read; latched on accepted start
//  base_write_address  in   address_width  first row to write; latched on accepted start
//  length              in   address_width  rows to sweep; latched on accepted start
//  writeback_en        in   1              1 = write results back; 0 = read-only sweep; latched on start
//  hold                in   1              1 = do not issue a row this cycle (bubble)
//  mem_read_address    out  address_width  row address to memory (combinational from read counter)
//  dp_in_valid         out  1              memory_output is a valid datapath input this cycle
//  mem_write_enable    out  1              write result row this cycle
//  mem_write_address   out  address_width  row address for the write
//  busy                out  1              high in ISSUE, DRAIN and DONE
//  finish              out  1              1-cycle pulse when the sweep is complete
// BEHAVIOUR
//  Reset: state=IDLE; counters, valid pipe, latched regs = 0. All outputs 0.
//   Asynchronous: mem_write_enable drops immediately even mid-sweep. No resume after reset.
//  State IDLE:
//   start & length!=0 -> ISSUE.
//   start & length==0 -> DONE; no reads, no writes.
//  State ISSUE:
//   Each cycle with hold=0: dp_in_valid=1, mem_read_address=base_rd+rcnt, rcnt++.
//   With hold=1: dp_in_valid=0, address held.
//   After the row with rcnt==length-1 is issued -> DRAIN.
//  State DRAIN:
//   dp_in_valid=0.
//   -> DONE when no valid bit remains in pipe stages below the last, i.e. the last result is writing now.
//  State DONE: finish=1 for exactly one cycle -> IDLE.
//  start outside IDLE is ignored, not queued.
//  Valid pipe: DP_LATENCY-bit shift register of dp_in_valid; bubbles from hold propagate as gaps.
//  Writes: mem_write_enable = pipe[DP_LATENCY-1] & writeback_en_latched.
//   mem_write_address = base_wr+wcnt; wcnt++ only on each performed write.
//  Address arithmetic is modulo 2^address_width; base+count wraps silently past the top.
//  Timing, no hold, start accepted in cycle 0: reads in cycles 1..L, writes in cycles 1+D..L+D, finish in L+D+1.
//   L=length, D=DP_LATENCY.
//   Each hold cycle during ISSUE delays finish by one cycle.
//  Read-only sweeps have the same timing; finish still waits for the datapath to drain.
//  In-place sweep (base_rd==base_wr) is legal: row i is written D cycles after it is read.
//   Any overlap with base_wr>base_rd is the caller's responsibility.
//  mem_read_address keeps its last value in DRAIN, DONE and IDLE; it is 0 after reset.
// TESTING
//  1. D=4, L=3, rd=0x10, wr=0x10, wb=1, no hold -> reads 0x10..0x12 in cycles 1..3; writes 0x10..0x12 in cycles 5..7; finish cycle 8.
//  2. Same as 1 with hold=1 in cycle 2 -> reads in cycles 1,3,4; writes in cycles 5,7,8; finish cycle 9; no write in cycle 6.
//  3. L=0, start -> no dp_in_valid, no write, finish in cycle 1, busy high in cycle 1 only.
//  4. wb=0, L=2, D=1 -> dp_in_valid in cycles 1..2; mem_write_enable never high; finish cycle 4.
//  5. rd=0xFFFFF, L=2 -> read addresses 0xFFFFF then 0x00000; start pulsed during ISSUE is ignored.
//  6. rst_n low during DRAIN with a write pending -> mem_write_enable=0 immediately; all outputs 0; next start sweeps from scratch.

Source files
------------

// File: rtl/mem_sweep_ctrl.sv
// Row sequencer for a wide vector memory: streams a block of rows through a
// fixed-latency datapath and optionally writes each result row back.
module mem_sweep_ctrl #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int address_width = 20,
  parameter int DP_LATENCY    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [address_width-1:0] base_read_address,
  input  logic [address_width-1:0] base_write_address,
  input  logic [address_width-1:0] length,
  input  logic                     writeback_en,
  input  logic                     hold,
  output logic [address_width-1:0] mem_read_address,
  output logic                     dp_in_valid,
  output logic                     mem_write_enable,
  output logic [address_width-1:0] mem_write_address,
  output logic                     busy,
  output logic                     finish
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state_reg;
  logic [address_width-1:0] base_rd_reg;
  logic [address_width-1:0] base_wr_reg;
  logic [address_width-1:0] length_reg;
  logic [address_width-1:0] rcnt_reg;
  logic [address_width-1:0] wcnt_reg;
  logic                     wb_reg;
  logic [DP_LATENCY-1:0]    pipe_reg;
  logic                     issue;
  logic                     last_row;
  logic                     pipe_low_busy;

  if (DP_LATENCY < 1) begin : g_bad_latency
    $error("mem_sweep_ctrl: DP_LATENCY must be at least 1");
  end
  if (element_width * no_of_units < 1) begin : g_bad_row
    $error("mem_sweep_ctrl: row width must be non-zero");
  end

  assign issue    = (state_reg == ISSUE) && !hold;
  assign last_row = (rcnt_reg == length_reg - address_width'(1));

  // Valid pipe mirrors the datapath; pipe_low_busy is set while any result
  // other than the one in the final stage is still in flight.
  if (DP_LATENCY == 1) begin : g_pipe_single
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_reg <= '0;
      else        pipe_reg <= issue;
    end
    assign pipe_low_busy = 1'b0;
  end else begin : g_pipe_multi
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_reg <= '0;
      else        pipe_reg <= {pipe_reg[DP_LATENCY-2:0], issue};
    end
    assign pipe_low_busy = |pipe_reg[DP_LATENCY-2:0];
  end

  assign mem_read_address  = base_rd_reg + rcnt_reg;
  assign dp_in_valid       = issue;
  assign mem_write_enable  = pipe_reg[DP_LATENCY-1] & wb_reg;
  assign mem_write_address = base_wr_reg + wcnt_reg;
  assign busy              = (state_reg != IDLE);
  assign finish            = (state_reg == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      base_rd_reg <= '0;
      base_wr_reg <= '0;
      length_reg  <= '0;
      rcnt_reg    <= '0;
      wcnt_reg    <= '0;
      wb_reg      <= 1'b0;
    end else begin
      if (mem_write_enable) wcnt_reg <= wcnt_reg + address_width'(1);
      case (state_reg)
        IDLE: begin
          if (start) begin
            wb_reg     <= writeback_en;
            length_reg <= length;
            // An empty sweep leaves the address registers alone so the read
            // address keeps showing the previous row.
            if (length != '0) begin
              base_rd_reg <= base_read_address;
              base_wr_reg <= base_write_address;
              rcnt_reg    <= '0;
              wcnt_reg    <= '0;
              state_reg   <= ISSUE;
            end else begin
              state_reg <= DONE;
            end
          end
        end
        ISSUE: begin
          if (!hold) begin
            if (last_row) state_reg <= DRAIN;
            else          rcnt_reg  <= rcnt_reg + address_width'(1);
          end
        end
        DRAIN: begin
          if (!pipe_low_busy) state_reg <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
